// File: rtl/motor_fb_pkg.sv
// Shared quadrature-encoder encodings and widths for the motor feedback and command paths.
package motor_fb_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Two's complement 2-bit step so it sign-extends directly into the accumulator
  localparam logic [1:0] DELTA_ZERO = 2'b00;
  localparam logic [1:0] DELTA_POS  = 2'b01;
  localparam logic [1:0] DELTA_NEG  = 2'b11;

  localparam int ERR_CNT_W = 8;
  localparam int FB_W      = 32;

  function automatic logic [1:0] qdec_delta(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = DELTA_ZERO;
    case ({prev, cur})
      {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: d = DELTA_POS;
      {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: d = DELTA_NEG;
      default: d = DELTA_ZERO;
    endcase
    return d;
  endfunction

  function automatic logic qdec_illegal(input logic [1:0] prev, input logic [1:0] cur);
    return (prev ^ cur) == 2'b11;
  endfunction

endpackage

// File: rtl/qdec_glitch_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows the synchronised
// input only once it has differed from the output for FILT_LEN consecutive samples.
module qdec_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      if (sync_p1 == dout) begin
        cnt <= '0;
      end else if (cnt == 4'(FILT_LEN - 1)) begin
        dout <= sync_p1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_feedback_qdec.sv
// x4 quadrature decoder producing a clamped signed edge count per sample window,
// plus a saturating count of illegal A/B transitions.
module motor_feedback_qdec
  import motor_fb_pkg::*;
#(
  parameter int PERIOD_CYCLES = 50000,
  parameter int FILT_LEN      = 4,
  parameter int CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        err_clr,
  output logic signed [FB_W-1:0]      feedback,
  output logic                        fb_valid,
  output logic                        dir_meas,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  localparam int WIN_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int LIM_I = (1 << (CNT_W - 1)) - 1;
  localparam logic signed [CNT_W:0] LIM_HI = (CNT_W + 1)'(LIM_I);
  localparam logic signed [CNT_W:0] LIM_LO = (CNT_W + 1)'(-LIM_I);

  function automatic logic signed [CNT_W-1:0] clamp_acc(input logic signed [CNT_W:0] sum);
    if (sum > LIM_HI) return LIM_HI[CNT_W-1:0];
    if (sum < LIM_LO) return LIM_LO[CNT_W-1:0];
    return sum[CNT_W-1:0];
  endfunction

  logic                     filt_a;
  logic                     filt_b;
  logic [1:0]               cur;
  logic [1:0]               prev;
  logic                     primed;
  logic [1:0]               dcode;
  logic                     illegal;
  logic signed [CNT_W-1:0]  acc;
  logic signed [CNT_W:0]    sum;
  logic signed [CNT_W-1:0]  acc_next;
  logic [WIN_W-1:0]         win;
  logic                     terminal;

  qdec_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (enc_a),
    .dout (filt_a)
  );

  qdec_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (enc_b),
    .dout (filt_b)
  );

  // Decode stage: nothing counts until prev has been loaded by a priming cycle
  always_comb begin
    cur     = {filt_a, filt_b};
    dcode   = DELTA_ZERO;
    illegal = 1'b0;
    if (enable && primed) begin
      dcode   = qdec_delta(prev, cur);
      illegal = qdec_illegal(prev, cur);
    end
    sum      = signed'({acc[CNT_W-1], acc}) + signed'({{(CNT_W - 1){dcode[1]}}, dcode});
    acc_next = clamp_acc(sum);
    terminal = (win == WIN_W'(PERIOD_CYCLES - 1));
  end

  // Accumulate / window stage: the terminal cycle's own edge closes into the reported window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= S00;
      primed   <= 1'b0;
      acc      <= '0;
      win      <= '0;
      feedback <= '0;
      fb_valid <= 1'b0;
    end else if (enable) begin
      prev     <= cur;
      primed   <= 1'b1;
      fb_valid <= terminal;
      if (terminal) begin
        feedback <= {{(FB_W - CNT_W){acc_next[CNT_W-1]}}, acc_next};
        acc      <= '0;
        win      <= '0;
      end else begin
        acc <= acc_next;
        win <= win + 1'b1;
      end
    end else begin
      primed   <= 1'b0;
      acc      <= '0;
      win      <= '0;
      fb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= ERR_CNT_W'(illegal);
    end else if (illegal && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign dir_meas = feedback[FB_W-1];

endmodule

// File: tb/tb_motor_feedback_qdec.sv
// Bench for motor_feedback_qdec: directed scenarios plus a randomized phase, all checked each
// cycle against a behavioural model; a second instance with CNT_W=4 exercises clamping.
module tb_motor_feedback_qdec;

  localparam int P  = 100;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] feedback, feedback4;
  logic        fb_valid, fb_valid4, dir_meas, dir_meas4;
  logic [7:0]  err_cnt, err_cnt4;

  always #5 clk = ~clk;

  motor_feedback_qdec #(.PERIOD_CYCLES(P), .FILT_LEN(FL), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
    .err_clr(err_clr), .feedback(feedback), .fb_valid(fb_valid), .dir_meas(dir_meas),
    .err_cnt(err_cnt)
  );

  motor_feedback_qdec #(.PERIOD_CYCLES(P), .FILT_LEN(FL), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
    .err_clr(err_clr), .feedback(feedback4), .fb_valid(fb_valid4), .dir_meas(dir_meas4),
    .err_cnt(err_cnt4)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h) at %0t", name, $signed(act), act,
               $signed(exp), exp, $time);
    end
  endtask

  // Behavioural model: encoder position is an index around the cycle 00,10,11,01 (A leads = +1)
  bit [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit       hist_a [8];
  bit       hist_b [8];
  bit       m_fa, m_fb, m_primed, m_valid, m_ill;
  bit [1:0] m_prev, m_cur;
  int       m_acc16, m_acc4, m_fb16, m_fb4, m_win, m_err, m_d, m_step;

  function automatic int pos_of(bit [1:0] ab);
    for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
    return 0;
  endfunction

  function automatic int clampi(int v, int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // A filtered level flips once the last FL synchroniser outputs (pins 2..FL+1 samples ago) all disagree with it
  function automatic bit filt_next(bit cur_lvl, bit h [8]);
    for (int i = 2; i < FL + 2; i++) if (h[i] == cur_lvl) return cur_lvl;
    return ~cur_lvl;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin hist_a[i] = 1'b0; hist_b[i] = 1'b0; end
      m_fa = 0; m_fb = 0; m_primed = 0; m_valid = 0; m_prev = 2'b00;
      m_acc16 = 0; m_acc4 = 0; m_fb16 = 0; m_fb4 = 0; m_win = 0; m_err = 0;
    end else begin
      m_cur = {m_fa, m_fb};
      m_d = 0;
      m_ill = 0;
      if (enable) begin
        if (m_primed) begin
          m_step = (pos_of(m_cur) - pos_of(m_prev) + 4) % 4;
          if (m_step == 1) m_d = 1;
          else if (m_step == 3) m_d = -1;
          else if (m_step == 2) m_ill = 1;
        end
        m_primed = 1;
        m_prev = m_cur;
        if (m_win == P - 1) begin
          m_fb16 = clampi(m_acc16 + m_d, 32767);
          m_fb4 = clampi(m_acc4 + m_d, 7);
          m_valid = 1; m_acc16 = 0; m_acc4 = 0; m_win = 0;
        end else begin
          m_acc16 = clampi(m_acc16 + m_d, 32767);
          m_acc4 = clampi(m_acc4 + m_d, 7);
          m_valid = 0; m_win++;
        end
      end else begin
        m_primed = 0; m_valid = 0; m_acc16 = 0; m_acc4 = 0; m_win = 0;
      end
      if (err_clr) m_err = m_ill ? 1 : 0;
      else if (m_ill && m_err < 255) m_err++;
      for (int i = 7; i > 0; i--) begin hist_a[i] = hist_a[i-1]; hist_b[i] = hist_b[i-1]; end
      hist_a[0] = enc_a;
      hist_b[0] = enc_b;
      m_fa = filt_next(m_fa, hist_a);
      m_fb = filt_next(m_fb, hist_b);
    end
    check("feedback", feedback, 32'(m_fb16));
    check("fb_valid", 32'(fb_valid), 32'(m_valid));
    check("dir_meas", 32'(dir_meas), 32'(m_fb16 < 0));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("feedback4", feedback4, 32'(m_fb4));
    check("fb_valid4", 32'(fb_valid4), 32'(m_valid));
    check("err_cnt4", 32'(err_cnt4), 32'(m_err));
  end

  // Stimulus helpers: inputs change 1 time unit after a falling edge
  int pidx = 0;

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_pos(input int p, input int n);
    pidx = ((p % 4) + 4) % 4;
    {enc_a, enc_b} = seq[pidx];
    hold(n);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (fb_valid) seen = 1;
    end
    #1;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no pulse, want fb_valid within 300 cycles at %0t", $time);
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (fb_valid) cnt++;
    end
    #1;
  endtask

  int pulses;
  int r;

  initial begin
    // Reset and idle windows
    hold(3);
    check("reset_feedback", feedback, 32'd0);
    check("reset_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    count_pulses(300, pulses);
    check("idle_pulses", 32'(pulses), 32'd3);
    check("idle_feedback", feedback, 32'd0);

    // Forward then reverse, one edge per 10 clocks
    for (int i = 1; i <= 36; i++) set_pos(i, 10);
    check("fwd_feedback", feedback, 32'd10);
    check("fwd_dir", 32'(dir_meas), 32'd0);
    check("fwd_feedback4", feedback4, 32'd7);
    for (int i = 35; i >= 0; i--) set_pos(i, 10);
    check("rev_feedback", feedback, 32'hFFFF_FFF6);
    check("rev_dir", 32'(dir_meas), 32'd1);
    check("rev_feedback4", feedback4, 32'hFFFF_FFF9);

    // Glitches: 2-cycle pulse rejected, 5-cycle pulse nets to zero
    wait_valid();
    hold(10);
    enc_a = 1'b1; hold(2); enc_a = 1'b0;
    wait_valid();
    check("glitch2_feedback", feedback, 32'd0);
    hold(10);
    enc_a = 1'b1; hold(5); enc_a = 1'b0;
    wait_valid();
    check("glitch5_feedback", feedback, 32'd0);

    // Edge decoded on the terminal cycle lands in the closing window
    wait_valid();
    hold(93);
    set_pos(1, 0);
    wait_valid();
    check("terminal_edge", feedback, 32'd1);
    wait_valid();
    check("after_terminal", feedback, 32'd0);
    set_pos(0, 0);
    wait_valid();
    wait_valid();

    // 20 forward edges inside one window: full-width count and CNT_W=4 clamp
    for (int i = 1; i <= 20; i++) set_pos(i, 4);
    wait_valid();
    check("burst_feedback", feedback, 32'd20);
    check("burst_feedback4", feedback4, 32'd7);

    // Illegal transitions, clear, saturation
    for (int i = 0; i < 3; i++) set_pos(pidx + 2, 8);
    check("illegal_err", 32'(err_cnt), 32'd3);
    wait_valid();
    wait_valid();
    check("illegal_feedback", feedback, 32'd0);
    err_clr = 1'b1; hold(1); err_clr = 1'b0; hold(1);
    check("err_clear", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) set_pos(pidx + 2, 7);
    check("err_saturate", 32'(err_cnt), 32'd255);
    set_pos(pidx + 2, 8);
    err_clr = 1'b1; hold(1); err_clr = 1'b0; hold(1);

    // Enable low mid-window, re-enable on 11, reset mid-window
    wait_valid();
    for (int i = 1; i <= 3; i++) set_pos(i, 10);
    wait_valid();
    check("three_edges", feedback, 32'd3);
    hold(49);
    enable = 1'b0;
    set_pos(2, 0);
    count_pulses(200, pulses);
    check("disabled_pulses", 32'(pulses), 32'd0);
    check("disabled_hold", feedback, 32'd3);
    enable = 1'b1;
    wait_valid();
    check("reprime_feedback", feedback, 32'd0);
    check("reprime_err", 32'(err_cnt), 32'd0);
    for (int i = 3; i <= 5; i++) set_pos(i, 10);
    set_pos(pidx + 2, 10);
    wait_valid();
    hold(40);
    rst_n = 1'b0;
    hold(1);
    check("rst_feedback", feedback, 32'd0);
    check("rst_valid", 32'(fb_valid), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_dir", 32'(dir_meas), 32'd0);
    hold(2);
    rst_n = 1'b1;
    hold(20);

    // Randomized walk with glitches, illegal jumps, clears, enable and reset drops
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        set_pos(pidx + (($urandom_range(0, 3) == 0) ? -1 : 1), $urandom_range(1, 12));
      end else if (r < 67) begin
        set_pos(pidx + 2, $urandom_range(5, 10));
      end else if (r < 80) begin
        if ($urandom_range(0, 1) == 1) begin
          enc_a = ~enc_a; hold($urandom_range(1, 4)); enc_a = ~enc_a;
        end else begin
          enc_b = ~enc_b; hold($urandom_range(1, 4)); enc_b = ~enc_b;
        end
        hold($urandom_range(1, 6));
      end else if (r < 87) begin
        err_clr = 1'b1; hold(1); err_clr = 1'b0;
      end else if (r < 93) begin
        enable = ~enable; hold($urandom_range(1, 60));
      end else if (r == 93) begin
        rst_n = 1'b0; hold($urandom_range(1, 3)); rst_n = 1'b1;
      end else begin
        enable = 1'b1; hold($urandom_range(1, 150));
      end
    end
    enable = 1'b1;
    hold(250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
